// File: rtl/alu_pkg.sv
// Shared ALU types: opcode enum, captured-entry struct and the ALU data width.
package alu_pkg;

  localparam int unsigned ALU_W = 4;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  typedef struct packed {
    logic [ALU_W-1:0] res;
    alu_op_e          op;
    logic             c;
    logic             z;
    logic             n;
  } alu_entry_t;

endpackage

// File: rtl/alu_result_fifo_if.sv
// Handshake/status bundle between the ALU, the result FIFO and its consumer.
// Optional ALU_RESULT_FIFO_STATS_EN adds stat_sel/stat_cnt.
interface alu_result_fifo_if
  import alu_pkg::*;
#(
  parameter int unsigned W     = ALU_W,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic            in_valid;
  logic            in_ready;
  logic [W:0]      in_res;
  alu_op_e         in_op;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_res;
  alu_op_e         out_op;
  logic            out_c;
  logic            out_z;
  logic            out_n;
  logic [CntW-1:0] count;
  logic            sticky_c;
  logic            clr_sticky;
`ifdef ALU_RESULT_FIFO_STATS_EN
  logic [1:0]      stat_sel;
  logic [7:0]      stat_cnt;
`endif

  // Environment side: ALU producer, consumer and status stage.
  modport master (
    output in_valid, in_res, in_op, out_ready, clr_sticky,
    input  in_ready, out_valid, out_res, out_op, out_c, out_z, out_n, count, sticky_c
`ifdef ALU_RESULT_FIFO_STATS_EN
    , output stat_sel
    , input  stat_cnt
`endif
  );

  // FIFO side.
  modport slave (
    input  in_valid, in_res, in_op, out_ready, clr_sticky,
    output in_ready, out_valid, out_res, out_op, out_c, out_z, out_n, count, sticky_c
`ifdef ALU_RESULT_FIFO_STATS_EN
    , input  stat_sel
    , output stat_cnt
`endif
  );

endinterface

// File: rtl/alu_flag_gen.sv
// Combinational C/Z/N derivation from a raw ALU result and its opcode.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int unsigned W = ALU_W
) (
  input  logic [W:0] res_i,
  input  alu_op_e    op_i,
  output logic       c_o,
  output logic       z_o,
  output logic       n_o
);

  // Carry only has meaning for arithmetic ops; logic ops report C=0.
  always_comb begin
    c_o = ((op_i == ALU_ADD) || (op_i == ALU_SUB)) ? res_i[W] : 1'b0;
    z_o = (res_i[W-1:0] == '0);
    n_o = res_i[W-1];
  end

endmodule

// File: rtl/alu_result_fifo.sv
// ALU result FIFO: captures result+opcode+flags, presents them in order over
// valid/ready, and keeps a sticky carry. Optional per-opcode push counters
// under ALU_RESULT_FIFO_STATS_EN.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int unsigned W     = ALU_W,
  parameter int unsigned DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  alu_result_fifo_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DEPTH-1:0][W-1:0] res_q;
  logic [DEPTH-1:0][1:0]   op_q;
  logic [DEPTH-1:0]        c_q, z_q, n_q;
  logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]         count_q;
  logic                    sticky_q;
  logic                    push, pop;
  logic                    c_new, z_new, n_new;

  alu_flag_gen #(
    .W (W)
  ) u_flag_gen (
    .res_i (bus.in_res),
    .op_i  (bus.in_op),
    .c_o   (c_new),
    .z_o   (z_new),
    .n_o   (n_new)
  );

  // Ready depends on occupancy only, so a pop never frees a slot in the same cycle.
  always_comb begin
    bus.in_ready  = (count_q != CntW'(DEPTH));
    bus.out_valid = (count_q != '0);
    push          = bus.in_valid & bus.in_ready;
    pop           = bus.out_valid & bus.out_ready;
    bus.out_res   = res_q[rd_ptr_q];
    bus.out_op    = alu_op_e'(op_q[rd_ptr_q]);
    bus.out_c     = c_q[rd_ptr_q];
    bus.out_z     = z_q[rd_ptr_q];
    bus.out_n     = n_q[rd_ptr_q];
    bus.count     = count_q;
    bus.sticky_c  = sticky_q;
  end

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q    <= '0;
      op_q     <= '0;
      c_q      <= '0;
      z_q      <= '0;
      n_q      <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        res_q[wr_ptr_q] <= bus.in_res[W-1:0];
        op_q[wr_ptr_q]  <= bus.in_op;
        c_q[wr_ptr_q]   <= c_new;
        z_q[wr_ptr_q]   <= z_new;
        n_q[wr_ptr_q]   <= n_new;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky carry: clear wins over a same-cycle set.
  always_ff @(posedge clk) begin
    if (rst || bus.clr_sticky) begin
      sticky_q <= 1'b0;
    end else if (push && c_new) begin
      sticky_q <= 1'b1;
    end
  end

`ifdef ALU_RESULT_FIFO_STATS_EN
  logic [3:0][7:0] stat_q;

  assign bus.stat_cnt = stat_q[bus.stat_sel];

  // Saturating per-opcode push counters, cleared with the sticky flag.
  always_ff @(posedge clk) begin
    if (rst || bus.clr_sticky) begin
      stat_q <= '0;
    end else if (push && (stat_q[bus.in_op] != 8'hFF)) begin
      stat_q[bus.in_op] <= stat_q[bus.in_op] + 8'd1;
    end
  end
`endif

endmodule
